// File: rtl/uart_baud_nco.sv
// uart_baud_nco: shared-increment NCO producing Rx oversample ticks and Tx bit ticks.
// Optional feature macro BAUD_RX_RESYNC_EN enables rx_resync handling and the rx_sample strobe.
module uart_baud_nco #(
   parameter int unsigned      ACC_W       = 24,
   parameter int unsigned      OSR         = 16,
   parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(618475),
   localparam int unsigned     PH_W        = $clog2(OSR)
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [ACC_W-1:0] cfg_inc,
   input  logic             cfg_load,
   input  logic             rx_resync,
   output logic             Rxclk_en,
   output logic             Txclk_en,
   output logic             rx_sample,
   output logic [PH_W-1:0]  rx_phase,
   output logic             cfg_err
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2 - 1);

   logic [ACC_W-1:0] inc_q, inc_d;
   logic [ACC_W-1:0] rx_acc_q, rx_acc_d;
   logic [ACC_W-1:0] tx_acc_q, tx_acc_d;
   logic [PH_W-1:0]  tx_div_q, tx_div_d;
   logic [PH_W-1:0]  rx_phase_q, rx_phase_d;
   logic             rxclk_en_q, rxclk_en_d;
   logic             txclk_en_q, txclk_en_d;
   logic             cfg_err_q, cfg_err_d;

   logic [ACC_W:0]   rx_sum;
   logic [ACC_W:0]   tx_sum;
   logic             resync_active;

   assign rx_sum = {1'b0, rx_acc_q} + {1'b0, inc_q};
   assign tx_sum = {1'b0, tx_acc_q} + {1'b0, inc_q};

`ifdef BAUD_RX_RESYNC_EN
   assign resync_active = rx_resync;
   assign rx_sample     = rxclk_en_q && (rx_phase_q == PH_MID);
`else
   logic unused_rx_resync;
   assign unused_rx_resync = rx_resync;
   assign resync_active    = 1'b0;
   assign rx_sample        = 1'b0;
`endif

   always_comb begin
      inc_d      = inc_q;
      rx_acc_d   = rx_acc_q;
      tx_acc_d   = tx_acc_q;
      tx_div_d   = tx_div_q;
      rx_phase_d = rx_phase_q;
      rxclk_en_d = 1'b0;
      txclk_en_d = 1'b0;
      cfg_err_d  = 1'b0;

      // A zero increment would stall both channels, so it is rejected and flagged.
      if (cfg_load) begin
         if (cfg_inc != '0) begin
            inc_d = cfg_inc;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      if (enable) begin
         rx_acc_d   = rx_sum[ACC_W-1:0];
         rxclk_en_d = rx_sum[ACC_W];
         if (rxclk_en_q) begin
            rx_phase_d = (rx_phase_q == PH_LAST) ? '0 : rx_phase_q + PH_W'(1);
         end

         tx_acc_d = tx_sum[ACC_W-1:0];
         if (tx_sum[ACC_W]) begin
            tx_div_d   = (tx_div_q == PH_LAST) ? '0 : tx_div_q + PH_W'(1);
            txclk_en_d = (tx_div_q == PH_LAST);
         end
      end

      // Resync realigns the Rx bit to the start edge and swallows any tick on this edge.
      if (resync_active) begin
         rx_acc_d   = '0;
         rx_phase_d = '0;
         rxclk_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         inc_q      <= DEFAULT_INC;
         rx_acc_q   <= '0;
         tx_acc_q   <= '0;
         tx_div_q   <= '0;
         rx_phase_q <= '0;
         rxclk_en_q <= 1'b0;
         txclk_en_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         inc_q      <= inc_d;
         rx_acc_q   <= rx_acc_d;
         tx_acc_q   <= tx_acc_d;
         tx_div_q   <= tx_div_d;
         rx_phase_q <= rx_phase_d;
         rxclk_en_q <= rxclk_en_d;
         txclk_en_q <= txclk_en_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   assign Rxclk_en = rxclk_en_q;
   assign Txclk_en = txclk_en_q;
   assign rx_phase = rx_phase_q;
   assign cfg_err  = cfg_err_q;

endmodule
